// File: rtl/alu_int_iter.sv
// Handshaked RV32I/RV64I OP/OP-IMM integer ALU. Single-cycle logic/add/compare;
// shifts run on an iterative shifter that moves SHIFT_STEP bits per cycle.
module alu_int_iter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1,
    parameter int unsigned TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic             in_alt,
    input  logic             in_is_imm,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = $clog2(XLEN + 1);

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        SK_SLL,
        SK_SRL,
        SK_SRA
    } shift_kind_e;

    state_e            state_q, state_d;
    shift_kind_e       kind_q, kind_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [SHW-1:0]    remaining_q, remaining_d;

    logic              accept;
    logic [XLEN-1:0]   op_b;
    logic [SHW-1:0]    shamt;
    logic              is_shift;
    logic              is_sub;
    logic              lt_s;
    logic              lt_u;
    logic [XLEN-1:0]   op_res;
    shift_kind_e       new_kind;
    logic [CW-1:0]     step_amt;
    logic [SHW-1:0]    rem_next;
    logic [XLEN-1:0]   sra_mask;
    logic [XLEN-1:0]   shifted;

    // Handshake: a flush blocks acceptance in the same cycle.
    assign in_ready = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    // Operand selection and request decode.
    assign op_b     = in_is_imm ? in_imm : in_rs2;
    assign shamt    = op_b[SHW-1:0];
    assign is_shift = (in_funct3 == F3_SLL) || (in_funct3 == F3_SRL);
    assign is_sub   = in_alt && !in_is_imm;
    assign lt_s     = $signed(in_rs1) < $signed(op_b);
    assign lt_u     = in_rs1 < op_b;

    // Single-cycle results; a shift only lands here when its amount is zero.
    always_comb begin
        op_res = in_rs1;
        case (in_funct3)
            F3_ADD:  op_res = is_sub ? (in_rs1 - op_b) : (in_rs1 + op_b);
            F3_SLL:  op_res = in_rs1;
            F3_SLT:  op_res = XLEN'(lt_s);
            F3_SLTU: op_res = XLEN'(lt_u);
            F3_XOR:  op_res = in_rs1 ^ op_b;
            F3_SRL:  op_res = in_rs1;
            F3_OR:   op_res = in_rs1 | op_b;
            F3_AND:  op_res = in_rs1 & op_b;
            default: op_res = in_rs1;
        endcase
    end

    always_comb begin
        new_kind = SK_SRL;
        if (in_funct3 == F3_SLL) begin
            new_kind = SK_SLL;
        end else if (in_alt) begin
            new_kind = SK_SRA;
        end
    end

    // One shifter iteration of min(SHIFT_STEP, remaining) bits.
    assign step_amt = (CW'(remaining_q) < CW'(SHIFT_STEP)) ? CW'(remaining_q) : CW'(SHIFT_STEP);
    assign rem_next = remaining_q - SHW'(step_amt);
    assign sra_mask = ~({XLEN{1'b1}} >> step_amt);

    // SRA keeps the original sign in the MSB at every step, so it is the fill bit.
    always_comb begin
        shifted = result_q >> step_amt;
        case (kind_q)
            SK_SLL:  shifted = result_q << step_amt;
            SK_SRL:  shifted = result_q >> step_amt;
            SK_SRA:  shifted = (result_q >> step_amt) | (result_q[XLEN-1] ? sra_mask : '0);
            default: shifted = result_q >> step_amt;
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        result_d    = result_q;
        tag_d       = tag_q;
        remaining_d = remaining_q;
        if (flush) begin
            state_d     = S_IDLE;
            remaining_d = '0;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    result_d    = shifted;
                    remaining_d = rem_next;
                    if (rem_next == '0) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
            if (accept) begin
                tag_d = in_tag;
                if (is_shift && (shamt != '0)) begin
                    state_d     = S_SHIFT;
                    result_d    = in_rs1;
                    remaining_d = shamt;
                    kind_d      = new_kind;
                end else begin
                    state_d     = S_DONE;
                    result_d    = op_res;
                    remaining_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            kind_q      <= SK_SLL;
            result_q    <= '0;
            tag_q       <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            result_q    <= result_d;
            tag_q       <= tag_d;
            remaining_q <= remaining_d;
        end
    end

    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign out_result = result_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_alu_int_iter.sv
// Bench for alu_int_iter: two instances (SHIFT_STEP 1 and 4) driven in lockstep
// and compared against an arithmetic reference model.
module tb_alu_int_iter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned STEP_A = 1;
    localparam int unsigned STEP_B = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [2:0]       in_funct3;
    logic             in_alt;
    logic             in_is_imm;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [XLEN-1:0]  in_imm;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    logic             a_in_ready, a_out_valid, a_busy;
    logic [XLEN-1:0]  a_out_result;
    logic [TAG_W-1:0] a_out_tag;
    logic             b_in_ready, b_out_valid, b_busy;
    logic [XLEN-1:0]  b_out_result;
    logic [TAG_W-1:0] b_out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_int_iter #(.XLEN(XLEN), .SHIFT_STEP(STEP_A), .TAG_W(TAG_W)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_funct3(in_funct3), .in_alt(in_alt), .in_is_imm(in_is_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_result(a_out_result), .out_tag(a_out_tag), .busy(a_busy)
    );

    alu_int_iter #(.XLEN(XLEN), .SHIFT_STEP(STEP_B), .TAG_W(TAG_W)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_funct3(in_funct3), .in_alt(in_alt), .in_is_imm(in_is_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_result(b_out_result), .out_tag(b_out_tag), .busy(b_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RISC-V integer semantics written directly from the ISA rules.
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                            input logic is_imm, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = 32'(b[4:0]);
        case (f3)
            3'd0:    return (alt && !is_imm) ? (a - b) : (a + b);
            3'd1:    return a << sh;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'($signed(a) >>> sh) : (a >> sh);
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] b, input int step);
        int sh;
        sh = int'(b[4:0]);
        if (((f3 == 3'd1) || (f3 == 3'd5)) && (sh != 0)) begin
            return (sh + step - 1) / step + 1;
        end
        return 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic alt, input logic is_imm,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [4:0] tag);
        in_funct3 = f3;
        in_alt    = alt;
        in_is_imm = is_imm;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_tag    = tag;
    endtask

    task automatic scramble();
        drive(3'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
    endtask

    // One transaction on both instances; optional back-pressure hold once done.
    task automatic do_op(input string name, input logic [2:0] f3, input logic alt,
                         input logic is_imm, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [4:0] tag, input int hold);
        logic [31:0] b;
        logic [31:0] exp;
        int exp_la, exp_lb, la, lb;
        bit busy_ok;
        b       = is_imm ? imm : rs2;
        exp     = ref_alu(f3, alt, is_imm, rs1, b);
        exp_la  = ref_lat(f3, b, STEP_A);
        exp_lb  = ref_lat(f3, b, STEP_B);
        la      = 0;
        lb      = 0;
        busy_ok = 1'b1;
        out_ready = 1'b0;
        drive(f3, alt, is_imm, rs1, rs2, imm, tag);
        in_valid = 1'b1;
        #1;
        check_eq({name, " in_ready"}, {62'd0, a_in_ready, b_in_ready}, 64'd3);
        step();
        in_valid = 1'b0;
        scramble();
        for (int c = 1; (c <= 80) && ((la == 0) || (lb == 0)); c++) begin
            if (!(a_busy && b_busy)) busy_ok = 1'b0;
            if ((la == 0) && a_out_valid) la = c;
            if ((lb == 0) && b_out_valid) lb = c;
            if ((la == 0) || (lb == 0)) step();
        end
        check_eq({name, " lat_a"}, 64'(la), 64'(exp_la));
        check_eq({name, " lat_b"}, 64'(lb), 64'(exp_lb));
        check_eq({name, " busy"}, 64'(busy_ok), 64'd1);
        check_eq({name, " res_a"}, 64'(a_out_result), 64'(exp));
        check_eq({name, " res_b"}, 64'(b_out_result), 64'(exp));
        check_eq({name, " tag_a"}, 64'(a_out_tag), 64'(tag));
        check_eq({name, " tag_b"}, 64'(b_out_tag), 64'(tag));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            scramble();
            #1;
            check_eq({name, " hold_rdy"}, {62'd0, a_in_ready, b_in_ready}, 64'd0);
            step();
            check_eq({name, " hold_vld"}, {62'd0, a_out_valid, b_out_valid}, 64'd3);
            check_eq({name, " hold_res"}, {a_out_result, b_out_result}, {exp, exp});
            check_eq({name, " hold_tag"}, 64'({a_out_tag, b_out_tag}), 64'({tag, tag}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq({name, " drained"}, {61'd0, a_out_valid, b_out_valid, a_busy | b_busy}, 64'd0);
    endtask

    logic [31:0] s1 [4];
    logic [31:0] s2 [4];
    logic [31:0] rimm;

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
        step();
        step();
        check_eq("reset_a", {a_out_result, 27'd0, a_out_tag}, 64'd0);
        check_eq("reset_flags", {60'd0, a_out_valid, a_busy, b_out_valid, b_busy}, 64'd0);
        rst = 1'b0;
        step();

        do_op("addi_alt", 3'd0, 1'b1, 1'b1, 32'h5, 32'h1234, 32'hFFFF_FFFB, 5'd3, 0);
        do_op("sub", 3'd0, 1'b1, 1'b0, 32'd5, 32'd7, 32'h0, 5'd4, 0);
        do_op("slti", 3'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h1, 5'd5, 0);
        do_op("sltiu", 3'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h1, 5'd6, 0);
        do_op("sltiu_max", 3'd3, 1'b0, 1'b1, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd7, 0);
        do_op("srai31", 3'd5, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 32'h0000_041F, 5'd8, 0);
        do_op("srli31", 3'd5, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 32'h0000_001F, 5'd9, 0);
        do_op("sll0", 3'd1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h20, 32'h0, 5'd10, 0);
        do_op("sll5", 3'd1, 1'b0, 1'b0, 32'h1, 32'h25, 32'h0, 5'd11, 0);
        do_op("bp_xor", 3'd4, 1'b0, 1'b0, 32'hA5A5_0F0F, 32'h0FF0_1234, 32'h0, 5'd12, 3);
        do_op("bp_sra", 3'd5, 1'b1, 1'b0, 32'hF000_1000, 32'd7, 32'h0, 5'd13, 3);

        // Four ANDs streamed back to back with the consumer always ready.
        for (int i = 0; i < 4; i++) begin
            s1[i] = $urandom;
            s2[i] = $urandom;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(3'd7, 1'b0, 1'b0, s1[i], s2[i], 32'h0, 5'(i + 20));
            in_valid = 1'b1;
            #1;
            check_eq("b2b_rdy", {62'd0, a_in_ready, b_in_ready}, 64'd3);
            @(posedge clk);
            #1;
            check_eq("b2b_vld", {62'd0, a_out_valid, b_out_valid}, 64'd3);
            check_eq("b2b_res", {a_out_result, b_out_result}, {s1[i] & s2[i], s1[i] & s2[i]});
            check_eq("b2b_tag", 64'({a_out_tag, b_out_tag}), 64'({5'(i + 20), 5'(i + 20)}));
        end
        in_valid = 1'b0;
        step();
        check_eq("b2b_end", {62'd0, a_out_valid, b_out_valid}, 64'd0);
        out_ready = 1'b0;

        // Flush on the second cycle of a 31-bit shift.
        drive(3'd1, 1'b0, 1'b1, 32'h1, 32'h0, 32'd31, 5'd1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        flush    = 1'b1;
        in_valid = 1'b1;
        drive(3'd0, 1'b0, 1'b0, 32'd1, 32'd2, 32'h0, 5'd2);
        #1;
        check_eq("flush_rdy", {62'd0, a_in_ready, b_in_ready}, 64'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_idle", {60'd0, a_out_valid, a_busy, b_out_valid, b_busy}, 64'd0);
        do_op("post_flush", 3'd6, 1'b0, 1'b0, 32'h00F0_0000, 32'h0000_000F, 32'h0, 5'd14, 0);

        // Reset while a shift is in flight.
        drive(3'd5, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 32'd31, 5'd15);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check_eq("rst_shift_a", {a_out_result, 27'd0, a_out_tag}, 64'd0);
        check_eq("rst_shift_b", {b_out_result, 27'd0, b_out_tag}, 64'd0);
        check_eq("rst_shift_flags", {60'd0, a_out_valid, a_busy, b_out_valid, b_busy}, 64'd0);
        rst = 1'b0;
        step();

        for (int n = 0; n < 60; n++) begin
            rimm = {{20{1'b0}}, 12'($urandom)};
            rimm = {{20{rimm[11]}}, rimm[11:0]};
            do_op("rand", 3'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
                  rimm, 5'($urandom), (n % 7 == 0) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_int_iter.md
Name: alu_int_iter

Overview:
- Parametrised, handshaked integer ALU for RV32I/RV64I-style OP and OP-IMM instructions.
- Supports register or immediate second operand; decodes funct3 plus the alt bit (instr[30]).
- Logical, add/sub and compare ops complete in one cycle.
- Shifts run on an iterative shifter at SHIFT_STEP bits per cycle, trading latency for area.
- Sits between decode/register-read and writeback; carries the destination tag through.

Parameters:
- XLEN, 32, datapath width; 32 or 64.
- SHIFT_STEP, 1, bits shifted per cycle; power of two, 1..XLEN.
- TAG_W, 5, width of the pass-through destination tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous abort of the held/in-flight op.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_funct3  in  3  000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
- in_alt  in  1  instr[30]: SUB when set on 000 register form; SRA when set on 101.
- in_is_imm  in  1  1 selects in_imm as operand B; 0 selects in_rs2.
- in_rs1  in  XLEN  operand A.
- in_rs2  in  XLEN  register operand B.
- in_imm  in  XLEN  sign-extended immediate.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  state is not IDLE.

Behaviour:
- Accept when in_valid & in_ready. in_ready = (state==IDLE) | (state==DONE & out_ready), and is 0 when flush is 1.
- States:
  - IDLE: waiting for a request.
  - SHIFT: shift iterations in progress.
  - DONE: out_valid=1; result held.
- On accept, B = in_is_imm ? in_imm : in_rs2; shamt = B[log2(XLEN)-1:0].
- Non-shift ops, and shifts with shamt==0, go directly to DONE with the result registered; out_valid is high on the cycle after accept.
- Shift with shamt>0: operand loaded into the shift register, remaining=shamt, go to SHIFT.
  - Each SHIFT cycle shifts by min(SHIFT_STEP, remaining) and decrements remaining.
  - When remaining reaches 0, go to DONE.
  - Latency = ceil(shamt/SHIFT_STEP)+1 cycles.
- Op semantics:
  - ADD = A+B, mod 2^XLEN.
  - SUB = A-B, only when in_alt & !in_is_imm; ADDI ignores in_alt.
  - SLT = signed A<B; SLTU = unsigned A<B (SLTIU compares against the sign-extended imm as unsigned). Both yield zero-extended 0/1.
  - SLL and SRL fill with 0; SRA fills with A[XLEN-1], taken from the original operand.
  - XOR, OR and AND are bitwise.
- DONE with out_ready=0: out_result and out_tag hold stable and in_ready=0.
- DONE with out_ready=1 and a new accept in the same cycle: the new op is taken (back-to-back, one result per cycle for 1-cycle ops). Otherwise return to IDLE.
- flush: next state IDLE and out_valid=0 regardless of state. A request presented in the same cycle is not accepted (in_ready=0). flush takes priority over an out_ready handshake; that result is discarded.
- rst: state=IDLE; out_valid=0, out_result=0, out_tag=0, busy=0, remaining=0. rst has priority over flush and over an in-progress shift.
- in_* values are sampled only at accept; changes while in SHIFT/DONE have no effect.
- in_funct3 is fully decoded; there are no illegal codes.

Test Plan:
- XLEN=32: ADDI rs1=0x00000005, imm=0xFFFFFFFB, alt=1 -> out_result 0x00000000, out_valid 1 cycle after accept, tag echoed. Register SUB 5-7 -> 0xFFFFFFFE.
- SLTI rs1=0xFFFFFFFF, imm=0x00000001 -> 1. SLTIU with the same operands -> 0. SLTIU rs1=0, imm=0xFFFFFFFF -> 1.
- SHIFT_STEP=1: SRAI rs1=0x80000000, shamt=31 -> 0xFFFFFFFF after 32 cycles. SRLI with the same operands -> 0x00000001. SLL by shamt=0 -> unchanged after 1 cycle.
- SHIFT_STEP=4: SLL rs1=0x00000001, rs2=0x00000025 (shamt=5) -> 0x00000020, latency 3 cycles; busy=1 throughout.
- Back-pressure and back-to-back: hold out_ready=0 for 3 cycles in DONE -> result and tag stable, in_ready=0. Then stream 4 ANDs with out_ready=1 -> 4 results on 4 consecutive cycles.
- Mid-shift events: flush on cycle 2 of a 31-bit shift -> out_valid stays 0, IDLE next cycle, next request accepted. rst in SHIFT -> all outputs 0 the following cycle.
